// File: rtl/display_scan_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package display_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    localparam disp_t DISP_RESET = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

    // Selects the nibbles at and above digit idx; all-zero there means a leading zero.
    function automatic logic [15:0] lead_mask(input logic [1:0] idx);
        return 16'hFFFF << {idx, 2'b00};
    endfunction

endpackage

// File: rtl/display_scan_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module display_scan_hex7seg
    import display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Holds a CPU-written 16-bit value and time-multiplexes it onto a common-anode
// 4-digit 7-segment display, one digit per SCAN_DIV cycles.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic [15:0] rd_data,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned      CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [15:0]      value_q, value_d;
    logic [3:0]       dp_mask_q, dp_mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    disp_t            disp_q, disp_d;

    logic       wrap;
    logic       blank;
    logic [3:0] nibble;
    logic [6:0] seg_dec;

    display_scan_hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        value_d   = value_q;
        dp_mask_d = dp_mask_q;
        if (wr_en) begin
            value_d   = wr_data;
            dp_mask_d = wr_dp;
        end

        wrap  = (cnt_q == CNT_MAX);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        // Output register looks at the pre-edge index/value, giving the
        // one-cycle lag after a write or a digit change.
        nibble = value_q[{idx_q, 2'b00} +: 4];
        blank  = BLANK_LEADING && (idx_q != 2'd0) && ((value_q & lead_mask(idx_q)) == 16'h0000);

        disp_d.an  = ~(4'b0001 << idx_q);
        disp_d.seg = blank ? SEG_BLANK : seg_dec;
        disp_d.dp  = ~dp_mask_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q   <= '0;
            dp_mask_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= DISP_RESET;
        end else begin
            value_q   <= value_d;
            dp_mask_q <= dp_mask_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
        end
    end

    assign rd_data = value_q;
    assign an      = disp_q.an;
    assign seg     = disp_q.seg;
    assign dp      = disp_q.dp;

endmodule
